// File: rtl/npu_pkg.sv
// Shared NPU definitions: the element-wise vector command format and its opcodes,
// used by the command scheduler and the layer microsequencer.
package npu_pkg;

  localparam logic [1:0] VOP_ADD         = 2'd0;
  localparam logic [1:0] VOP_MUL         = 2'd1;
  localparam logic [1:0] VOP_SCALE_SHIFT = 2'd2;
  localparam logic [1:0] VOP_CLAMP       = 2'd3;

  typedef struct packed {
    logic [1:0]  opcode;
    logic [15:0] length;
    logic [15:0] src0_base;
    logic [15:0] src1_base;
    logic [15:0] dst_base;
    logic [7:0]  scale;
    logic [7:0]  shift;
  } vec_cmd_t;

  // A zero length would wrap to 65536 elements inside the engine.
  function automatic logic cmd_is_empty(input vec_cmd_t cmd);
    return cmd.length == 16'd0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; read/write pointers carry an extra
// wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_en  = push && !full;
  assign pop_en   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_en)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is data only and needs no reset; the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vec_cmd_sched.sv
// Two-requester round-robin command scheduler for vec_engine: queues commands
// in order, issues one at a time, and reports a completion record per command.
module vec_cmd_sched
  import npu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  rq_valid,
  output logic [1:0]                  rq_ready,
  input  vec_cmd_t [1:0]              rq_cmd,
  input  logic [1:0][TAG_W-1:0]       rq_tag,
  output logic                        eng_cmd_valid,
  input  logic                        eng_cmd_ready,
  output logic [1:0]                  eng_opcode,
  output logic [15:0]                 eng_length,
  output logic [15:0]                 eng_src0_base,
  output logic [15:0]                 eng_src1_base,
  output logic [15:0]                 eng_dst_base,
  output logic [7:0]                  eng_scale,
  output logic [7:0]                  eng_shift,
  input  logic                        eng_done,
  output logic                        cpl_valid,
  output logic                        cpl_req_id,
  output logic [TAG_W-1:0]            cpl_tag,
  output logic                        cpl_err,
  output logic [$clog2(DEPTH):0]      q_count,
  output logic                        busy
);

  typedef struct packed {
    vec_cmd_t         cmd;
    logic [TAG_W-1:0] tag;
    logic             req_id;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_CPL} state_t;

  state_t     state;
  state_t     state_nxt;
  logic       rr_ptr;
  logic [1:0] grant;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  entry_t     push_entry;
  entry_t     head;
  entry_t     iss;
  logic       iss_err;
  vec_cmd_t   eng_cmd;

  // Round-robin pointer only matters when both requesters contend.
  always_comb begin
    grant = 2'b00;
    case (rq_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = rr_ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  assign rq_ready   = full ? 2'b00 : grant;
  assign push       = |(rq_valid & rq_ready);
  assign push_entry = '{cmd: rq_cmd[grant[1]], tag: rq_tag[grant[1]], req_id: grant[1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         rr_ptr <= 1'b0;
    else if (push && (&rq_valid))    rr_ptr <= ~grant[1];
  end

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .empty     (empty),
    .full      (full),
    .count     (q_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // eng_done outside S_WAIT is deliberately ignored.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = cmd_is_empty(head.cmd) ? S_CPL : S_ISSUE;
        end
      end
      S_ISSUE: if (eng_cmd_ready) state_nxt = S_WAIT;
      S_WAIT:  if (eng_done)      state_nxt = S_CPL;
      S_CPL:                      state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (pop) iss <= head;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      iss_err <= 1'b0;
    else if (pop) iss_err <= cmd_is_empty(head.cmd);
  end

  // Outputs are gated by state so the unreset issue register never leaks out.
  assign eng_cmd_valid = (state == S_ISSUE);
  assign eng_cmd       = eng_cmd_valid ? iss.cmd : '0;
  assign eng_opcode    = eng_cmd.opcode;
  assign eng_length    = eng_cmd.length;
  assign eng_src0_base = eng_cmd.src0_base;
  assign eng_src1_base = eng_cmd.src1_base;
  assign eng_dst_base  = eng_cmd.dst_base;
  assign eng_scale     = eng_cmd.scale;
  assign eng_shift     = eng_cmd.shift;

  assign cpl_valid  = (state == S_CPL);
  assign cpl_req_id = cpl_valid & iss.req_id;
  assign cpl_tag    = cpl_valid ? iss.tag : '0;
  assign cpl_err    = cpl_valid & iss_err;

  assign busy = (state != S_IDLE) || !empty;

endmodule

// File: tb/tb_vec_cmd_sched.sv
// Directed bench for vec_cmd_sched with a behavioural engine: L elements take
// 3L+1 cycles from the issue cycle to done.
`timescale 1ns/1ps
module tb_vec_cmd_sched;
  import npu_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [1:0]             rq_valid = 2'b00;
  logic [1:0]             rq_ready;
  vec_cmd_t [1:0]         rq_cmd = '0;
  logic [1:0][TAG_W-1:0]  rq_tag = '0;
  logic                   eng_cmd_valid;
  logic                   eng_cmd_ready = 1'b0;
  logic [1:0]             eng_opcode;
  logic [15:0]            eng_length, eng_src0_base, eng_src1_base, eng_dst_base;
  logic [7:0]             eng_scale, eng_shift;
  logic                   eng_done = 1'b0;
  logic                   cpl_valid, cpl_req_id, cpl_err;
  logic [TAG_W-1:0]       cpl_tag;
  logic [2:0]             q_count;
  logic                   busy;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  // Engine controls: tasks only raise *_req, the engine process owns *_used/*_ack.
  int hold_req = 0, hold_used = 0;
  int spur_req = 0, spur_ack = 0;
  int busy_cnt = 0;
  int eng_valid_cnt = 0;
  int eng_cyc_q[$];
  int cpl_cyc_q[$];
  logic [5:0] cpl_q[$];

  vec_cmd_sched #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .rq_valid(rq_valid), .rq_ready(rq_ready),
    .rq_cmd(rq_cmd), .rq_tag(rq_tag),
    .eng_cmd_valid(eng_cmd_valid), .eng_cmd_ready(eng_cmd_ready),
    .eng_opcode(eng_opcode), .eng_length(eng_length),
    .eng_src0_base(eng_src0_base), .eng_src1_base(eng_src1_base),
    .eng_dst_base(eng_dst_base), .eng_scale(eng_scale), .eng_shift(eng_shift),
    .eng_done(eng_done), .cpl_valid(cpl_valid), .cpl_req_id(cpl_req_id),
    .cpl_tag(cpl_tag), .cpl_err(cpl_err), .q_count(q_count), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt      = 0;
      hold_used     = hold_req;
      spur_ack      = spur_req;
      eng_done      = 1'b0;
      eng_cmd_ready = 1'b0;
    end else begin
      eng_done = 1'b0;
      if (spur_ack != spur_req) begin
        eng_done = 1'b1;
        spur_ack = spur_req;
      end
      if (hold_used < hold_req) begin
        eng_cmd_ready = 1'b0;
        if (eng_cmd_valid) hold_used++;
      end else begin
        eng_cmd_ready = 1'b1;
      end
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) eng_done = 1'b1;
      end else if (eng_cmd_valid && eng_cmd_ready) begin
        eng_cyc_q.push_back(cyc);
        busy_cnt = 3 * int'(eng_length) + 1;
      end
    end
    if (eng_cmd_valid) eng_valid_cnt++;
    if (cpl_valid) begin
      cpl_cyc_q.push_back(cyc);
      cpl_q.push_back({cpl_err, cpl_req_id, cpl_tag});
    end
  end

  function automatic vec_cmd_t mk(input logic [1:0] op, input logic [15:0] len,
                                  input logic [15:0] s0, input logic [15:0] s1,
                                  input logic [15:0] dst, input logic [7:0] sc,
                                  input logic [7:0] sh);
    vec_cmd_t c;
    c = '{opcode: op, length: len, src0_base: s0, src1_base: s1,
          dst_base: dst, scale: sc, shift: sh};
    return c;
  endfunction

  // Presents one command until accepted; pc is the handshake cycle (-1 if never).
  task automatic push_one(input int r, input vec_cmd_t c, input logic [TAG_W-1:0] t,
                          output int pc);
    pc = -1;
    @(negedge clk);
    rq_valid[r] = 1'b1;
    rq_cmd[r]   = c;
    rq_tag[r]   = t;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (rq_ready[r]) begin
        pc = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rq_valid[r] = 1'b0;
    #1;
  endtask

  task automatic wait_cpl(input int target, input int budget);
    for (int i = 0; i < budget && cpl_q.size() < target; i++) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rq_ready !== 2'b00) $display("FAIL rst_rq_ready: got %b want 00", rq_ready); else passed++;
    checks++; if ({eng_cmd_valid, cpl_valid, cpl_err, busy} !== 4'b0000)
      $display("FAIL rst_ctrl: got %b want 0000", {eng_cmd_valid, cpl_valid, cpl_err, busy}); else passed++;
    checks++; if (q_count !== 3'd0) $display("FAIL rst_q_count: got %0d want 0", q_count); else passed++;
    checks++; if ({eng_opcode, eng_length, eng_src0_base, eng_src1_base, eng_dst_base, eng_scale, eng_shift} !== 82'd0)
      $display("FAIL rst_eng_fields: got %0h want 0", {eng_opcode, eng_length, eng_dst_base}); else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({busy, q_count, eng_cmd_valid, cpl_valid} !== 6'd0)
      $display("FAIL post_rst_idle: got %b want 0", {busy, q_count, eng_cmd_valid, cpl_valid}); else passed++;
  endtask

  task automatic test_single_add;
    vec_cmd_t c;
    int pc, n_e, n_c;
    c   = mk(VOP_ADD, 16'd4, 16'h0100, 16'h0200, 16'h0300, 8'h11, 8'h02);
    n_e = eng_cyc_q.size();
    n_c = cpl_q.size();
    push_one(0, c, 4'd5, pc);
    checks++; if (pc < 0) $display("FAIL add_accept: got no accept want accept"); else passed++;
    checks++; if ({q_count, eng_cmd_valid} !== {3'd1, 1'b0})
      $display("FAIL add_queued: got q=%0d v=%b want q=1 v=0", q_count, eng_cmd_valid); else passed++;
    @(negedge clk);
    #1;
    checks++; if (eng_cmd_valid !== 1'b1) $display("FAIL add_issue_latency: got valid=%b want 1 two cycles after push", eng_cmd_valid); else passed++;
    checks++; if ({eng_opcode, eng_length, eng_src0_base, eng_src1_base, eng_dst_base, eng_scale, eng_shift} !== c)
      $display("FAIL add_eng_fields: got %h want %h",
               {eng_opcode, eng_length, eng_src0_base, eng_src1_base, eng_dst_base, eng_scale, eng_shift}, c); else passed++;
    wait_cpl(n_c + 1, 60);
    checks++; if (cpl_q.size() != n_c + 1) $display("FAIL add_cpl_count: got %0d want %0d", cpl_q.size(), n_c + 1); else passed++;
    if (cpl_q.size() > n_c && eng_cyc_q.size() > n_e) begin
      checks++; if (eng_cyc_q[n_e] != pc + 2) $display("FAIL add_issue_cycle: got %0d want %0d", eng_cyc_q[n_e], pc + 2); else passed++;
      checks++; if (cpl_cyc_q[n_c] != eng_cyc_q[n_e] + 14)
        $display("FAIL add_cpl_cycle: got %0d want %0d", cpl_cyc_q[n_c], eng_cyc_q[n_e] + 14); else passed++;
      checks++; if (cpl_q[n_c] !== {1'b0, 1'b0, 4'd5}) $display("FAIL add_cpl_rec: got %b want 0_0_0101", cpl_q[n_c]); else passed++;
    end
  endtask

  task automatic test_zero_len;
    int pc, n_c, n_v;
    repeat (3) @(negedge clk);
    n_c = cpl_q.size();
    n_v = eng_valid_cnt;
    push_one(1, mk(VOP_MUL, 16'd0, 16'h0010, 16'h0020, 16'h0030, 8'h01, 8'h00), 4'd3, pc);
    repeat (6) @(negedge clk);
    #1;
    checks++; if (cpl_q.size() != n_c + 1) $display("FAIL zero_cpl_count: got %0d want %0d", cpl_q.size(), n_c + 1); else passed++;
    if (cpl_q.size() > n_c) begin
      checks++; if (cpl_cyc_q[n_c] != pc + 2) $display("FAIL zero_cpl_cycle: got %0d want %0d", cpl_cyc_q[n_c], pc + 2); else passed++;
      checks++; if (cpl_q[n_c] !== {1'b1, 1'b1, 4'd3}) $display("FAIL zero_cpl_rec: got %b want 1_1_0011", cpl_q[n_c]); else passed++;
    end
    checks++; if (eng_valid_cnt != n_v) $display("FAIL zero_no_issue: got %0d valid cycles want 0", eng_valid_cnt - n_v); else passed++;
  endtask

  task automatic test_ready_stall;
    vec_cmd_t c;
    int pc, n_e, n_c;
    repeat (3) @(negedge clk);
    c   = mk(VOP_SCALE_SHIFT, 16'd2, 16'h4000, 16'h5000, 16'h0AAA, 8'h7F, 8'h03);
    n_e = eng_cyc_q.size();
    n_c = cpl_q.size();
    hold_req = hold_req + 5;
    push_one(0, c, 4'd9, pc);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      checks++; if ({eng_cmd_valid, eng_cmd_ready, eng_opcode, eng_length, eng_dst_base, eng_scale, eng_shift} !==
                    {1'b1, 1'b0, c.opcode, c.length, c.dst_base, c.scale, c.shift})
        $display("FAIL stall_hold_%0d: got v=%b len=%0d dst=%h want v=1 len=2 dst=0aaa", k, eng_cmd_valid, eng_length, eng_dst_base); else passed++;
    end
    wait_cpl(n_c + 1, 60);
    if (eng_cyc_q.size() > n_e && cpl_q.size() > n_c) begin
      checks++; if (eng_cyc_q[n_e] != pc + 7) $display("FAIL stall_issue_cycle: got %0d want %0d", eng_cyc_q[n_e], pc + 7); else passed++;
      checks++; if (cpl_cyc_q[n_c] != pc + 15) $display("FAIL stall_cpl_cycle: got %0d want %0d", cpl_cyc_q[n_c], pc + 15); else passed++;
    end else begin
      checks++; $display("FAIL stall_timeout: got %0d completions want %0d", cpl_q.size() - n_c, 1);
    end
  endtask

  task automatic test_spurious_done;
    int pc_a, pc_b, n_c;
    repeat (3) @(negedge clk);
    #1;
    n_c = cpl_q.size();
    spur_req++;
    repeat (4) @(negedge clk);
    #1;
    checks++; if ({cpl_q.size() == n_c, busy, q_count} !== {1'b1, 1'b0, 3'd0})
      $display("FAIL spur_idle: got cpls=%0d busy=%b q=%0d want 0/0/0", cpl_q.size() - n_c, busy, q_count); else passed++;
    hold_req = hold_req + 3;
    push_one(0, mk(VOP_ADD, 16'd1, 16'h0001, 16'h0002, 16'h0003, 8'h00, 8'h00), 4'd6, pc_a);
    push_one(1, mk(VOP_MUL, 16'd1, 16'h0011, 16'h0012, 16'h0013, 8'h00, 8'h00), 4'd7, pc_b);
    spur_req++;
    repeat (2) @(negedge clk);
    #1;
    checks++; if ({eng_cmd_valid, q_count} !== {1'b1, 3'd1})
      $display("FAIL spur_issue: got v=%b q=%0d want v=1 q=1", eng_cmd_valid, q_count); else passed++;
    checks++; if (cpl_q.size() != n_c) $display("FAIL spur_no_cpl: got %0d completions want 0", cpl_q.size() - n_c); else passed++;
    wait_cpl(n_c + 2, 80);
    checks++; if (cpl_q.size() != n_c + 2) $display("FAIL spur_cpl_count: got %0d want %0d", cpl_q.size() - n_c, 2); else passed++;
    if (cpl_q.size() >= n_c + 2) begin
      checks++; if ({cpl_q[n_c], cpl_q[n_c+1]} !== {1'b0, 1'b0, 4'd6, 1'b0, 1'b1, 4'd7})
        $display("FAIL spur_cpl_order: got %b %b want 0_0_0110 0_1_0111", cpl_q[n_c], cpl_q[n_c+1]); else passed++;
    end
  endtask

  task automatic test_back_to_back;
    int n[2];
    int gseq[$];
    int n_c;
    bit saw_full;
    logic [5:0] exp_rec;
    repeat (3) @(negedge clk);
    n    = '{0, 0};
    n_c  = cpl_q.size();
    saw_full = 1'b0;
    for (int c = 0; c < 300 && (n[0] < 6 || n[1] < 6); c++) begin
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
        rq_valid[r] = (n[r] < 6);
        rq_tag[r]   = TAG_W'(r * 8 + n[r]);
        rq_cmd[r]   = mk(VOP_CLAMP, 16'd1, 16'h0200, 16'h0300, 16'(r * 16 + n[r]), 8'h05, 8'h01);
      end
      #1;
      if (q_count == 3'd4) begin
        saw_full = 1'b1;
        checks++; if (rq_ready !== 2'b00) $display("FAIL b2b_full_ready: got %b want 00 at q_count=4", rq_ready); else passed++;
      end
      if (rq_ready[0]) begin
        gseq.push_back(0);
        n[0]++;
      end else if (rq_ready[1]) begin
        gseq.push_back(1);
        n[1]++;
      end
    end
    @(negedge clk);
    rq_valid = 2'b00;
    checks++; if (saw_full !== 1'b1) $display("FAIL b2b_saw_full: got %b want 1", saw_full); else passed++;
    checks++; if (gseq.size() != 12) $display("FAIL b2b_grant_count: got %0d want 12", gseq.size()); else passed++;
    for (int k = 0; k < 12 && k < gseq.size(); k++) begin
      checks++; if (gseq[k] != k % 2) $display("FAIL b2b_grant_%0d: got %0d want %0d", k, gseq[k], k % 2); else passed++;
    end
    wait_cpl(n_c + 12, 400);
    checks++; if (cpl_q.size() != n_c + 12) $display("FAIL b2b_cpl_count: got %0d want 12", cpl_q.size() - n_c); else passed++;
    for (int k = 0; k < 12 && n_c + k < cpl_q.size(); k++) begin
      exp_rec = {1'b0, 1'(k % 2), 4'((k % 2) * 8 + k / 2)};
      checks++; if (cpl_q[n_c + k] !== exp_rec) $display("FAIL b2b_cpl_%0d: got %b want %b", k, cpl_q[n_c + k], exp_rec); else passed++;
    end
  endtask

  task automatic test_reset_midcmd;
    int pc, n_c;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      push_one(0, mk(VOP_ADD, 16'd5, 16'h0700, 16'h0800, 16'(16'h0900 + k), 8'h00, 8'h00), TAG_W'(k), pc);
      checks++; if (pc < 0) $display("FAIL rstmid_accept_%0d: got no accept want accept", k); else passed++;
    end
    checks++; if ({q_count, busy, eng_cmd_valid} !== {3'd3, 1'b1, 1'b0})
      $display("FAIL rstmid_pre: got q=%0d busy=%b v=%b want q=3 busy=1 v=0", q_count, busy, eng_cmd_valid); else passed++;
    n_c = cpl_q.size();
    #2;
    rst = 1'b1;
    #1;
    checks++; if ({rq_ready, eng_cmd_valid, cpl_valid, cpl_err, busy, q_count} !== 9'd0)
      $display("FAIL rstmid_async: got %b want 0", {rq_ready, eng_cmd_valid, cpl_valid, cpl_err, busy, q_count}); else passed++;
    checks++; if ({eng_length, eng_dst_base, cpl_tag} !== 36'd0)
      $display("FAIL rstmid_fields: got %h want 0", {eng_length, eng_dst_base, cpl_tag}); else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    checks++; if (cpl_q.size() != n_c) $display("FAIL rstmid_no_cpl: got %0d completions want 0", cpl_q.size() - n_c); else passed++;
    checks++; if ({q_count, busy, eng_cmd_valid} !== 5'd0)
      $display("FAIL rstmid_post: got q=%0d busy=%b v=%b want 0", q_count, busy, eng_cmd_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_zero_len();
    test_ready_stall();
    test_spurious_done();
    test_back_to_back();
    test_reset_midcmd();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vec_cmd_sched.md
# vec_cmd_sched

Command scheduler in front of `vec_engine`.
- Accepts element-wise vector commands from two requesters: requester 0 is the layer microsequencer, requester 1 is the host CSR path.
- Arbitrates between them round-robin and buffers accepted commands in an in-order FIFO.
- Issues one command at a time to the engine and waits for its `done`.
- Returns a one-cycle completion record carrying the requester id and tag.
- Rejects zero-length commands without touching the engine, because the engine would otherwise run 65536 elements.

## Interface
Parameters:
- DEPTH, 4: command FIFO entries; power of two, ≥2.
- TAG_W, 4: requester-supplied tag width.

Ports:
- clk  in  1  clock; one clock domain.
- rst  in  1  reset, asynchronous, active-high; clears FIFO, arbiter and FSM.
- rq_valid  in  2  per-requester command valid (bit i = requester i).
- rq_ready  out  2  per-requester accept; command transfers on valid&ready.
- rq_cmd  in  2×vec_cmd_t  per-requester command payload.
- rq_tag  in  2×TAG_W  per-requester tag.
- eng_cmd_valid  out  1  to engine `cmd_valid`.
- eng_cmd_ready  in  1  from engine `cmd_ready`.
- eng_opcode  out  2  0=ADD 1=MUL 2=SCALE_SHIFT 3=CLAMP.
- eng_length / eng_src0_base / eng_src1_base / eng_dst_base  out  16 each.
- eng_scale / eng_shift  out  8 each.
- eng_done  in  1  engine completion pulse.
- cpl_valid  out  1  one-cycle completion pulse; no backpressure.
- cpl_req_id  out  1  requester of the completed command.
- cpl_tag  out  TAG_W  tag of the completed command.
- cpl_err  out  1  1 = rejected (length 0), engine not used.
- q_count  out  clog2(DEPTH)+1  FIFO occupancy.
- busy  out  1  FSM not idle or FIFO non-empty.

## Operation
Arbitration:
- `rq_ready[i] = !full && grant[i]`.
- When only one requester is valid, it is granted.
- When both are valid, the one at the round-robin pointer is granted. The pointer moves to the other requester after each grant that happens with both valid.
- At most one push per cycle.
- `full` is the registered occupancy; a pop in the same cycle does not free a slot for that cycle.

FIFO:
- Each entry is {cmd, tag, req_id}.
- Strict in-order issue.

FSM states: S_IDLE, S_ISSUE, S_WAIT, S_CPL.
- S_IDLE, FIFO non-empty: pop the head into the issue register.
  - If length==0, go to S_CPL with err=1.
  - Otherwise go to S_ISSUE.
- S_ISSUE: `eng_cmd_valid=1` with the eng_* fields driven from the issue register. Go to S_WAIT on `eng_cmd_ready`; hold until it is seen.
- S_WAIT: go to S_CPL on `eng_done`.
  - `eng_done` seen in any other state is ignored.
- S_CPL: `cpl_valid=1` with req_id/tag/err from the issue register, then go to S_IDLE.

Reset:
- Outputs: `rq_ready=0`, `eng_cmd_valid=0`, `cpl_valid=0`, `cpl_err=0`, `q_count=0`, `busy=0`, all eng_* fields 0.
- Round-robin pointer resets to requester 0.
- The engine shares this reset net, inverted to its `rst_n`. Reset mid-command discards the FIFO and any in-flight command, and emits no completion.

## Timing
- Push at edge N → head visible cycle N+1 → S_IDLE pops at edge N+1 → `eng_cmd_valid` high cycle N+2.
- The engine captures the command at the S_ISSUE edge. It then spends 3 cycles per element and asserts `done` 3·L+1 cycles after the issue cycle. `cpl_valid` follows one cycle after `done`.
- Back-to-back commands: S_CPL → S_IDLE → S_ISSUE gives a 2-cycle gap between `eng_done` and the next `eng_cmd_valid`.
- Zero-length command: `cpl_valid` with err=1 two cycles after the push edge.
- Simultaneous push and pop: `q_count` is unchanged.
- Pointer wrap: read and write pointers wrap modulo DEPTH; the extra MSB distinguishes full from empty.

## Structure
- Shared package (npu_pkg): `vec_cmd_t` packed struct {opcode[1:0], length, src0_base, src1_base, dst_base, scale, shift} and opcode localparams VOP_ADD..VOP_CLAMP, for use by both this block and the microsequencer.
- One sub-module: `sync_fifo`, parameterised width/depth with count output.
- Round-robin arbiter and FSM are inline.

## Test plan
- Single ADD, L=4, tag 5 from requester 0 → eng fields match; `eng_cmd_valid` 2 cycles after push; `cpl_valid` with tag 5, req 0, err 0 exactly 14 cycles after the issue cycle.
- Both requesters valid every cycle, 6 commands each, DEPTH=4 → grants alternate 0,1,0,1…; `rq_ready` drops while `q_count`=4; completions arrive in push order.
- Length 0 from requester 1, tag 3 → no `eng_cmd_valid`; `cpl_valid` err=1, tag 3 two cycles after push.
- `eng_cmd_ready` held low 5 cycles → `eng_cmd_valid` and fields stable for all 5 cycles; issue occurs on the first ready cycle.
- Spurious `eng_done` in S_IDLE and S_ISSUE → no `cpl_valid`; FIFO unaffected.
- `rst` asserted while in S_WAIT with 3 queued → all outputs 0 asynchronously; no completion; `q_count`=0 after release.
